// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO: MULT/MULTU shift-add, DIV/DIVU restoring division, WIDTH iterations plus a sign-fix cycle.
// Optional `MDU_DIV0_FLAG_EN adds a sticky div_zero output that is cleared by the next accepted start.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               div_q, neg_a, neg_b, b_zero;
  logic [WIDTH-1:0]   mc;   // multiplicand, or divisor
  logic [WIDTH-1:0]   sh;   // multiplier or dividend, consumed MSB first
  logic [2*WIDTH-1:0] acc;  // product, or {remainder, quotient}
  logic [CW-1:0]      cnt;

  logic               in_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc_iter, prod_fix;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  assign in_signed = ~op[0];
  assign a_abs     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (in_signed && b[WIDTH-1]) ? -b : b;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, trial subtract for divide.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mc};
    if (div_q) begin
      if (!div_diff[WIDTH]) acc_iter = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_iter = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_iter = {acc[2*WIDTH-2:0], 1'b0} + (sh[WIDTH-1] ? {{WIDTH{1'b0}}, mc} : '0);
    end
  end

  // Sign correction; a zero divisor leaves remainder = |a|, so re-signing it restores a.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quot_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_q) begin
      res_hi = rem_fix;
      res_lo = b_zero ? '1 : quot_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_q    <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      mc       <= '0;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
`ifdef MDU_DIV0_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            div_q    <= op[1];
            neg_a    <= in_signed & a[WIDTH-1];
            neg_b    <= in_signed & b[WIDTH-1];
            b_zero   <= (b == '0);
            mc       <= op[1] ? b_abs : a_abs;
            sh       <= op[1] ? a_abs : b_abs;
            acc      <= '0;
            cnt      <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div_zero <= 1'b0;
`endif
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        CALC: begin
          acc <= acc_iter;
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
          div_zero <= div_q & b_zero;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in the execute stage beside the ALU. Its hi/lo outputs feed the 32-bit 2:1 result-select mux ahead of writeback, which picks between the ALU result and HI/LO for MFHI/MFLO.
- Pipeline control stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation (sampled only in IDLE)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write a into HI
- mtlo  input  1  write a into LO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when hi/lo are updated by an operation

Behaviour:
- Reset (rst_n=0, asynchronous): hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0. Reset mid-operation aborts the operation; no partial result is kept.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - latch op and operand signs;
  - latch |a| and |b| for signed ops, raw values for unsigned ops;
  - clear the accumulator and counter; go to CALC; busy=1.
- CALC, one iteration per edge, WIDTH edges (E1..E32 for WIDTH=32):
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After the last iteration, go to FIX.
- FIX, edge E33:
  - Apply sign correction:
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write hi/lo: product high/low, or remainder/quotient.
  - done=1 and busy=0 after E33; go to IDLE.
- done is a single-cycle pulse; it is 0 in every other cycle.
- Timing for WIDTH=32: busy high for exactly 33 cycles; result visible 33 edges after the start edge.
- start while busy: ignored; the operation in flight is unaffected.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; the write lands at the next edge.
  - mthi and mtlo together: both registers load a.
  - While busy: ignored.
  - start and mthi/mtlo together in IDLE: start wins and the move is dropped.
- Divide by zero (DIV or DIVU, b=0): lo=all ones, hi=a as originally presented; same 33-cycle latency.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- hi/lo hold their values at all times except on the FIX write, a move, or reset.
- The operand inputs a, b and op are not required to stay stable after the start edge.

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN.
- When defined: an extra output port div_zero (1 bit, reset 0).
  - Set together with the done pulse when a DIV/DIVU completes with b=0.
  - Holds until the next accepted start or reset.
- When undefined: the port does not exist and divide-by-zero behaviour is otherwise identical.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly 33 edges after start; busy high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. With MDU_DIV0_FLAG_EN, div_zero=1 from done onward until the next start.
- During busy, pulse start with new operands and pulse mthi with a=0xAAAAAAAA -> both ignored and the original result is produced. In IDLE, mtlo with a=0x55 -> lo=0x55 next edge, hi unchanged.
- Deassert rst_n asynchronously 10 cycles into a MULT -> hi=lo=0, busy=0, done=0 immediately. After release, MULTU 6*7 -> lo=42, hi=0 with normal latency.
